// File: rtl/switch_reader_pkg.sv
// rtl/switch_reader_pkg.sv - shared IO decode constants for the switch reader
package switch_reader_pkg;

    // CPU-visible register selector on switchAddr
    typedef enum logic [1:0] {
        SW_ADDR_SNAP_LO = 2'b00,
        SW_ADDR_SNAP_HI = 2'b01,
        SW_ADDR_LIVE    = 2'b10,
        SW_ADDR_STATUS  = 2'b11
    } sw_addr_e;

    // Bit positions inside the status word
    localparam int ST_READY   = 0;
    localparam int ST_OVERRUN = 1;

    // Status word: flags in the low bits, everything else zero
    function automatic logic [15:0] status_word(input logic ready, input logic overrun);
        logic [15:0] w;
        w = 16'h0000;
        w[ST_READY]   = ready;
        w[ST_OVERRUN] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and press pulse
module btn_debounce
    import switch_reader_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 500000,
    parameter int CNT_W        = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             prev_q;

    // Two-stage synchronizer, debounce state and one-cycle-delayed level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    // Count consecutive cycles that disagree with the accepted level; any agreement restarts
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/switch_reader.sv
// rtl/switch_reader.sv - board switch MMIO reader with debounced snapshot on submit
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 500000,
    parameter int CNT_W        = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SwitchCtrl,
    input  logic        ioRead,
    input  logic [1:0]  switchAddr,
    input  logic [23:0] switches,
    input  logic        submit,
    output logic [15:0] read_data,
    output logic        pending
);

    logic [23:0] sw_sync_q;
    logic [23:0] live_q;
    logic [23:0] snap_q;
    logic [23:0] snap_d;
    logic        ready_q;
    logic        ready_d;
    logic        overrun_q;
    logic        overrun_d;
    logic        press;
    logic        consume;

    btn_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (submit),
        .press_o (press)
    );

    assign consume = SwitchCtrl && ioRead && (switchAddr == SW_ADDR_SNAP_LO);

    // Switch synchronizer plus snapshot and flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_sync_q <= '0;
            live_q    <= '0;
            snap_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sw_sync_q <= switches;
            live_q    <= sw_sync_q;
            snap_q    <= snap_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // A press captures; a simultaneous consuming read only clears the stale overrun
    always_comb begin
        snap_d    = snap_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        if (press) begin
            snap_d    = live_q;
            ready_d   = 1'b1;
            overrun_d = consume ? 1'b0 : (overrun_q | ready_q);
        end else if (consume) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // Zero-latency read mux; the CPU samples the pre-edge value
    always_comb begin
        read_data = 16'h0000;
        if (SwitchCtrl && ioRead) begin
            case (sw_addr_e'(switchAddr))
                SW_ADDR_SNAP_LO: read_data = snap_q[15:0];
                SW_ADDR_SNAP_HI: read_data = {8'h00, snap_q[23:16]};
                SW_ADDR_LIVE:    read_data = live_q[15:0];
                SW_ADDR_STATUS:  read_data = status_word(ready_q, overrun_q);
                default:         read_data = 16'h0000;
            endcase
        end
    end

    assign pending = ready_q;

endmodule

// File: tb/tb_switch_reader.sv
// tb/tb_switch_reader.sv - self-checking bench for switch_reader
module tb_switch_reader;

    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        SwitchCtrl;
    logic        ioRead;
    logic [1:0]  switchAddr;
    logic [23:0] switches;
    logic        submit;
    logic [15:0] read_data;
    logic        pending;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;

    // Reference model state
    logic [23:0]   m_sw_pipe [2];
    logic          m_sub_pipe [2];
    logic [DB-1:0] m_hist;
    logic          m_level;
    logic          m_rose;
    logic [23:0]   m_snap;
    logic          m_rdy;
    logic          m_ovr;

    typedef struct {
        logic        sel;
        logic        rd;
        logic [1:0]  addr;
        logic [23:0] sw;
        logic        sub;
        logic [15:0] exp_rd;
        logic        exp_pend;
    } vec_t;
    vec_t tbl [13];

    switch_reader #(.DEBOUNCE_CNT(DB), .CNT_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .SwitchCtrl (SwitchCtrl),
        .ioRead     (ioRead),
        .switchAddr (switchAddr),
        .switches   (switches),
        .submit     (submit),
        .read_data  (read_data),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (!reset && dut.u_debounce.press_o) press_cnt <= press_cnt + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read();
        if (!(SwitchCtrl && ioRead)) return 16'h0000;
        case (switchAddr)
            2'b00:   return m_snap[15:0];
            2'b01:   return {8'h00, m_snap[23:16]};
            2'b10:   return m_sw_pipe[1][15:0];
            default: return {14'b0, m_ovr, m_rdy};
        endcase
    endfunction

    task automatic m_reset();
        m_sw_pipe[0] = '0; m_sw_pipe[1] = '0;
        m_sub_pipe[0] = 1'b0; m_sub_pipe[1] = 1'b0;
        m_hist = '0; m_level = 1'b0; m_rose = 1'b0;
        m_snap = '0; m_rdy = 1'b0; m_ovr = 1'b0;
    endtask

    // One clock edge of the spec: button level flips only after DB consecutive
    // synchronized samples disagree with it; a rise captures on the following edge.
    task automatic m_edge();
        logic taking;
        taking = SwitchCtrl && ioRead && (switchAddr == 2'b00);
        if (m_rose) begin
            m_snap = m_sw_pipe[1];
            m_ovr  = m_rdy && !taking;
            m_rdy  = 1'b1;
        end else if (taking) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        m_hist = {m_hist[DB-2:0], m_sub_pipe[1]};
        m_rose = 1'b0;
        if (m_hist == {DB{~m_level}}) begin
            m_level = ~m_level;
            m_rose  = m_level;
        end
        m_sw_pipe[1]  = m_sw_pipe[0];  m_sw_pipe[0]  = switches;
        m_sub_pipe[1] = m_sub_pipe[0]; m_sub_pipe[0] = submit;
    endtask

    task automatic tick();
        #1;
        check16("model_read", read_data, m_read());
        check16("model_pending", {15'b0, pending}, {15'b0, m_rdy});
        m_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_bus(input logic sel, input logic rd, input logic [1:0] addr);
        SwitchCtrl = sel; ioRead = rd; switchAddr = addr;
    endtask

    initial begin
        int p0;
        int hold;

        tbl[0]  = '{1'b1, 1'b1, 2'b10, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'b10, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'b10, 24'h12ABCD, 1'b1, 16'hABCD, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0001, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 2'b01, 24'h12ABCD, 1'b1, 16'h0012, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 2'b00, 24'h12ABCD, 1'b1, 16'hABCD, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 2'b11, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'b10, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 2'b10, 24'h12ABCD, 1'b1, 16'h0000, 1'b0};

        reset = 1'b1;
        set_bus(1'b0, 1'b0, 2'b00);
        switches = '0;
        submit = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset mid-debounce with switches present
        switches = 24'hA5A5A5;
        submit = 1'b1;
        ticks(4);
        #2 reset = 1'b1;
        m_reset();
        #1;
        for (int a = 0; a < 4; a++) begin
            set_bus(1'b1, 1'b1, 2'(a));
            #1 check16($sformatf("reset_read_%0d", a), read_data, 16'h0000);
        end
        check16("reset_pending", {15'b0, pending}, 16'h0000);
        check16("reset_counter", {13'b0, dut.u_debounce.cnt_q}, 16'h0000);
        submit = 1'b0;
        switches = 24'h12ABCD;
        @(posedge clock);
        #1 reset = 1'b0;

        // Clean press, table driven
        for (int i = 0; i < 13; i++) begin
            set_bus(tbl[i].sel, tbl[i].rd, tbl[i].addr);
            switches = tbl[i].sw;
            submit = tbl[i].sub;
            #1;
            check16($sformatf("tbl_read_%0d", i), read_data, tbl[i].exp_rd);
            check16($sformatf("tbl_pend_%0d", i), {15'b0, pending}, {15'b0, tbl[i].exp_pend});
            tick();
        end

        // Bouncy press then bouncy release
        set_bus(1'b0, 1'b0, 2'b00);
        submit = 1'b0;
        ticks(8);
        p0 = press_cnt;
        submit = 1'b1; tick();
        submit = 1'b0; tick();
        submit = 1'b1; tick();
        submit = 1'b1; tick();
        submit = 1'b0; tick();
        submit = 1'b1;
        ticks(6);
        check16("bounce_early", {15'b0, pending}, 16'h0000);
        tick();
        check16("bounce_ready", {15'b0, pending}, 16'h0001);
        ticks(6);
        check16("bounce_one_pulse", 16'(press_cnt - p0), 16'd1);
        set_bus(1'b1, 1'b1, 2'b00);
        tick();
        set_bus(1'b0, 1'b0, 2'b00);
        p0 = press_cnt;
        submit = 1'b0; tick();
        submit = 1'b1; tick();
        submit = 1'b0; tick();
        submit = 1'b0; tick();
        submit = 1'b1; tick();
        submit = 1'b0;
        ticks(10);
        check16("release_no_pulse", 16'(press_cnt - p0), 16'd0);
        check16("release_pending", {15'b0, pending}, 16'h0000);

        // Overrun
        switches = 24'h000001; submit = 1'b1; ticks(10);
        submit = 1'b0; ticks(8);
        switches = 24'h000002; submit = 1'b1; ticks(10);
        set_bus(1'b1, 1'b1, 2'b11);
        #1 check16("ovr_status", read_data, 16'h0003);
        set_bus(1'b1, 1'b1, 2'b00);
        #1 check16("ovr_snap", read_data, 16'h0002);
        tick();
        set_bus(1'b1, 1'b1, 2'b11);
        #1 check16("ovr_cleared", read_data, 16'h0000);
        set_bus(1'b0, 1'b0, 2'b00);

        // Collision: press pulse on the same edge as a consuming read
        submit = 1'b0; ticks(8);
        switches = 24'h000005; submit = 1'b1; ticks(10);
        submit = 1'b0; ticks(8);
        switches = 24'h00BEEF; submit = 1'b1;
        ticks(6);
        set_bus(1'b1, 1'b1, 2'b00);
        #1;
        check16("coll_pulse", {15'b0, dut.u_debounce.press_o}, 16'h0001);
        check16("coll_pre_read", read_data, 16'h0005);
        tick();
        set_bus(1'b1, 1'b1, 2'b11);
        #1 check16("coll_status", read_data, 16'h0001);
        set_bus(1'b1, 1'b1, 2'b00);
        #1 check16("coll_snap", read_data, 16'hBEEF);

        // Non-consuming reads and live lag
        set_bus(1'b1, 1'b1, 2'b01); tick();
        set_bus(1'b1, 1'b1, 2'b10); tick();
        set_bus(1'b1, 1'b1, 2'b11); tick();
        check16("nc_ready", {15'b0, pending}, 16'h0001);
        switches = 24'h345678;
        set_bus(1'b1, 1'b1, 2'b10);
        tick();
        check16("live_lag1", read_data, 16'hBEEF);
        tick();
        check16("live_lag2", read_data, 16'h5678);
        set_bus(1'b0, 1'b1, 2'b11);
        #1 check16("nosel_zero", read_data, 16'h0000);

        // Randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                submit = ~submit;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
            end
            hold--;
            switches = 24'($urandom);
            set_bus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) != 0 && switchAddr == 2'b00) SwitchCtrl = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
